// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and counter sizing.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter needs at least one bit even when W=1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bi;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bo;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;

  modport master (output start, A, B, Bi, input busy, done, D, Bo, ovf);
  modport slave  (input start, A, B, Bi, output busy, done, D, Bo, ovf);
`else
  modport master (output start, A, B, Bi, input busy, done, D, Bo);
  modport slave  (input start, A, B, Bi, output busy, done, D, Bo);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the column borrows.
// Purely combinational.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor D = A - B - Bi, LSB first through one cell; done pulses W+1 cycles after accept.
// start is only sampled in IDLE; SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(W);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_d;
  logic            r_bor;
  logic            r_bo;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic            r_ovf;
`endif

  logic            w_d;
  logic            w_bout;
  logic            w_last;
  logic [W-1:0]    w_d_next;

  full_subtractor u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_bor),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  assign w_last = (r_cnt == CW'(W - 1));

  // Result bits enter at the MSB so the LSB computed first ends up at bit 0.
  generate
    if (W == 1) begin : g_d_one
      assign w_d_next = w_d;
    end else begin : g_d_wide
      assign w_d_next = {w_d, r_d[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_bor   <= 1'b0;
      r_bo    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_bor   <= bus.Bi;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_d   <= w_d_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bo    <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the MSB differs from borrow out of it.
            r_ovf   <= r_bor ^ w_bout;
`endif
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.D    = r_d;
  assign bus.Bo   = r_bo;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor with borrow chain: computes D = A - B - Bi one bit per clock, LSB first, through a single one-bit full-subtractor cell and a borrow flop.
- Inverse-direction counterpart of the team's combinational W-bit ripple adder.
- Trades W cycles of latency for one cell of logic.
- Used by the game-of-life datapath where area matters more than throughput, e.g. neighbour-count and generation-counter decrements.

Parameters:
- W, 4, operand/result width in bits (W >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  W  minuend; captured on the accepting edge.
- B  input  W  subtrahend; captured on the accepting edge.
- Bi  input  1  borrow in; captured on the accepting edge.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; result valid.
- D  output  W  difference.
- Bo  output  1  borrow out; 1 when A < B + Bi (unsigned).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, D=0, Bo=0; shift registers, borrow flop and bit counter cleared. Reset mid-RUN aborts immediately, with no partial result and no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN, on an edge where start=1:
  - load A and B into shift registers;
  - borrow flop <= Bi;
  - counter <= 0.
- RUN, each edge:
  - cell inputs: a = A_sr[0], b = B_sr[0], bin = borrow flop;
  - d = a^b^bin; bout = (~a&b) | (~(a^b)&bin);
  - d shifts into the D register at the MSB end (D shifts right);
  - A_sr and B_sr shift right; borrow flop <= bout; counter++.
- RUN -> DONE on the edge where counter == W-1. That is the W-th processing edge. Bo <= final bout on that same edge.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency: start accepted at edge k; done high in the cycle after edge k+W.
- D and Bo hold their value from DONE until the next accepted start.
  - D is not guaranteed stable during RUN (partial shifts are visible).
  - Bo holds until the RUN -> DONE edge of the next operation.
- start in RUN or DONE is ignored, with no queueing. start held high in DONE is ignored in DONE and is accepted in the following IDLE cycle.
- Arithmetic: modulo 2^W. Bi=1 with A=B gives D = all ones and Bo=1.
- Counter width: $clog2(W) bits, minimum 1. For W=1, RUN lasts exactly one edge.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - ovf = two's-complement signed overflow of A - B - Bi, i.e. the borrow into the MSB XOR the borrow out of the MSB.
  - Registered on the RUN -> DONE edge, held with D.
  - Reset value 0.
- Undefined: port ovf absent; no extra flops.

Decomposition:
- Shared package serial_sub_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module: full_subtractor (a, b, bin -> d, bout), purely combinational, instantiated once.
- All sequencing lives in serial_subtractor.

Test Plan:
1. Reset then A=9, B=3, Bi=0, start pulse -> done exactly 5 cycles after the start edge (W=4); D=6, Bo=0; busy high for 5 cycles.
2. A=3, B=9, Bi=0 -> D=4'hA, Bo=1.
3. A=5, B=5, Bi=1 -> D=4'hF, Bo=1. A=0, B=0, Bi=0 -> D=0, Bo=0.
4. start re-asserted on every cycle of RUN with A=1, B=1 -> ignored; result is from the first operands. start held through DONE -> second operation begins on the cycle after DONE.
5. Assert rst_n=0 at the 2nd RUN cycle -> outputs 0 asynchronously, no done pulse. After release, a new start gives a correct result.
6. With SERIAL_SUB_OVF_EN: A=8 (-8), B=1, Bi=0 -> D=7, Bo=0, ovf=1. A=7, B=1 -> D=6, ovf=0. Compile without the macro -> builds with no ovf port.
